// File: rtl/mcu_spi_slave.sv
// ---------------------------------------------------------------------------
// mcu_spi_slave
//   SPI slave front end (mode 0, MSB first) between the MCU SPI pins and the
//   command decoder. SCK, MOSI and SSEL are oversampled in the clk domain.
//   The first byte of each SSEL-framed transaction is presented as the
//   command, later bytes as parameters. The decoder's response byte is
//   shifted back out on MISO.
//
// Ports
//   clk          system clock, at least 16x the SCK frequency
//   rst_n        asynchronous active-low reset
//   sck          SPI clock (idle low)
//   mosi         SPI data in
//   ssel_n       SPI select, active low
//   miso         SPI data out (0 while deselected)
//   miso_oe      high while a transaction is active
//   input_data   response byte from the command decoder
//   cmd_ready    one-cycle strobe: command byte complete
//   param_ready  one-cycle strobe: parameter byte complete
//   cmd_data     last command byte
//   param_data   last parameter byte
//   byte_cnt     completed bytes in the current transaction (saturating)
//   bit_cnt      bits received in the current byte
//
// Build option
//   MCU_SPI_SSEL_FILTER_EN : when defined, SSEL deassertion is accepted only
//   after SSEL_FILT_LEN consecutive high synchronised samples.
// ---------------------------------------------------------------------------
`timescale 1ns / 1ps

module mcu_spi_slave #(
   parameter int SYNC_STAGES   = 2,
   parameter int BYTECNT_W     = 32,
   parameter int SSEL_FILT_LEN = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 sck,
   input  logic                 mosi,
   input  logic                 ssel_n,
   output logic                 miso,
   output logic                 miso_oe,
   input  logic [7:0]           input_data,
   output logic                 cmd_ready,
   output logic                 param_ready,
   output logic [7:0]           cmd_data,
   output logic [7:0]           param_data,
   output logic [BYTECNT_W-1:0] byte_cnt,
   output logic [2:0]           bit_cnt
);

   if (SYNC_STAGES < 2 || SSEL_FILT_LEN < 1) begin : g_param_check
      $error("mcu_spi_slave: SYNC_STAGES must be >= 2 and SSEL_FILT_LEN >= 1");
   end

   // ------------------------------------------------------------------
   // Input synchronisers plus one history flop per input
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sck_sync_q, mosi_sync_q, ssel_sync_q;
   logic                   sck_prev_q, mosi_prev_q, ssel_prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_sync_q  <= '0;
         mosi_sync_q <= '0;
         ssel_sync_q <= '1;   // deselected, so release from reset is not a select edge
         sck_prev_q  <= 1'b0;
         mosi_prev_q <= 1'b0;
         ssel_prev_q <= 1'b1;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples the pre-edge value of its neighbour, forming a true chain.
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
         ssel_sync_q <= {ssel_sync_q[SYNC_STAGES-2:0], ssel_n};
         sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
         mosi_prev_q <= mosi_sync_q[SYNC_STAGES-1];
         ssel_prev_q <= ssel_sync_q[SYNC_STAGES-1];
      end
   end

   logic sck_cur, ssel_cur, mosi_smp;
   logic sck_rise, sck_fall, ssel_fall, ssel_release;

   assign sck_cur   = sck_sync_q[SYNC_STAGES-1];
   assign ssel_cur  = ssel_sync_q[SYNC_STAGES-1];
   // MOSI is taken from its history flop: the value one cycle before the SCK
   // rise became visible, well inside the half-period MOSI is held stable.
   assign mosi_smp  = mosi_prev_q;
   assign sck_rise  = ~sck_prev_q &  sck_cur;
   assign sck_fall  =  sck_prev_q & ~sck_cur;
   assign ssel_fall =  ssel_prev_q & ~ssel_cur;

`ifdef MCU_SPI_SSEL_FILTER_EN
   // Count consecutive high SSEL samples; release only on the
   // SSEL_FILT_LEN-th one so short high glitches leave the frame intact.
   localparam int                FILT_W   = $clog2(SSEL_FILT_LEN + 1);
   localparam logic [FILT_W-1:0] FILT_LIM = FILT_W'(SSEL_FILT_LEN - 1);

   logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;

   always_comb begin
      filt_cnt_d = filt_cnt_q;
      if (!ssel_cur)                filt_cnt_d = '0;
      else if (filt_cnt_q != FILT_LIM) filt_cnt_d = filt_cnt_q + FILT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) filt_cnt_q <= '0;
      else        filt_cnt_q <= filt_cnt_d;
   end

   assign ssel_release = ssel_cur && (filt_cnt_q == FILT_LIM);
`else
   assign ssel_release = ssel_cur;
`endif

   // ------------------------------------------------------------------
   // Transaction state
   // ------------------------------------------------------------------
   logic                 active_q, active_d;
   logic [2:0]           bit_cnt_q, bit_cnt_d;
   logic [BYTECNT_W-1:0] byte_cnt_q, byte_cnt_d;
   logic [7:0]           rx_q, rx_d, tx_q, tx_d;
   logic [7:0]           cmd_data_q, cmd_data_d, param_data_q, param_data_d;
   logic                 cmd_ready_q, cmd_ready_d, param_ready_q, param_ready_d;
   logic                 clear_pend_q, clear_pend_d;
   logic                 assert_det, deassert_det, byte_done;
   logic [7:0]           rx_next;

   // A select edge only opens a frame when none is open; with the filter a
   // glitch produces a low-going edge that must not restart the frame.
   assign assert_det   = ~active_q & ssel_fall;
   assign deassert_det =  active_q & ssel_release;
   assign rx_next      = {rx_q[6:0], mosi_smp};

   always_comb begin
      // NOTE: every next-state signal takes its hold value first, so no
      // path through the branches below can leave one unassigned (no latch).
      active_d      = active_q;
      bit_cnt_d     = bit_cnt_q;
      byte_cnt_d    = byte_cnt_q;
      rx_d          = rx_q;
      tx_d          = tx_q;
      cmd_data_d    = cmd_data_q;
      param_data_d  = param_data_q;
      cmd_ready_d   = 1'b0;
      param_ready_d = 1'b0;
      clear_pend_d  = 1'b0;
      byte_done     = 1'b0;

      // Deferred clear: a byte completed on the deselect cycle, so the
      // counters were held through its strobe cycle and clear now.
      if (clear_pend_q) begin
         bit_cnt_d  = '0;
         byte_cnt_d = '0;
      end

      if (assert_det) begin
         active_d   = 1'b1;
         bit_cnt_d  = '0;
         byte_cnt_d = '0;
         rx_d       = '0;
         tx_d       = input_data;
      end else if (active_q) begin
         if (sck_rise) begin
            rx_d      = rx_next;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
               byte_done = 1'b1;
               if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + BYTECNT_W'(1);
               if (byte_cnt_q == '0) begin
                  cmd_data_d  = rx_next;
                  cmd_ready_d = 1'b1;
               end else begin
                  param_data_d  = rx_next;
                  param_ready_d = 1'b1;
               end
            end
         end else if (sck_fall) begin
            // At a byte boundary fetch the decoder's next response byte.
            tx_d = (bit_cnt_q == 3'd0) ? input_data : {tx_q[6:0], 1'b0};
         end

         if (deassert_det) begin
            active_d = 1'b0;
            tx_d     = '0;
            if (byte_done) begin
               clear_pend_d = 1'b1;
            end else begin
               bit_cnt_d  = '0;
               byte_cnt_d = '0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q      <= 1'b0;
         bit_cnt_q     <= '0;
         byte_cnt_q    <= '0;
         rx_q          <= '0;
         tx_q          <= '0;
         cmd_data_q    <= '0;
         param_data_q  <= '0;
         cmd_ready_q   <= 1'b0;
         param_ready_q <= 1'b0;
         clear_pend_q  <= 1'b0;
      end else begin
         active_q      <= active_d;
         bit_cnt_q     <= bit_cnt_d;
         byte_cnt_q    <= byte_cnt_d;
         rx_q          <= rx_d;
         tx_q          <= tx_d;
         cmd_data_q    <= cmd_data_d;
         param_data_q  <= param_data_d;
         cmd_ready_q   <= cmd_ready_d;
         param_ready_q <= param_ready_d;
         clear_pend_q  <= clear_pend_d;
      end
   end

   // tx_q is cleared on deselect, so MISO idles low without extra gating.
   assign miso        = tx_q[7];
   assign miso_oe     = active_q;
   assign cmd_ready   = cmd_ready_q;
   assign param_ready = param_ready_q;
   assign cmd_data    = cmd_data_q;
   assign param_data  = param_data_q;
   assign byte_cnt    = byte_cnt_q;
   assign bit_cnt     = bit_cnt_q;

endmodule

// File: tb/tb_mcu_spi_slave.sv
// ---------------------------------------------------------------------------
// tb_mcu_spi_slave
//   Directed bench for mcu_spi_slave. A vector table of SPI bytes with their
//   expected strobe, byte count, data and MISO response is played through a
//   mode-0 master model, followed by hand-written sequences for partial
//   bytes, mid-byte reset, SSEL glitches and SCK activity while deselected.
// ---------------------------------------------------------------------------
`timescale 1ns / 1ps

module tb_mcu_spi_slave;

   logic        clk = 1'b0;
   logic        rst_n, sck, mosi, ssel_n;
   logic        miso, miso_oe, cmd_ready, param_ready;
   logic [7:0]  input_data, cmd_data, param_data;
   logic [31:0] byte_cnt;
   logic [2:0]  bit_cnt;

   int n_vec = 0;
   int n_err = 0;

   // Strobe bookkeeping, updated every falling clk edge
   int   cmd_cnt = 0, param_cnt = 0, wide_cnt = 0;
   logic strobe_prev = 1'b0;

   // Values captured at the strobe of the most recent byte
   int          cap_kind;   // 0 none, 1 command, 2 parameter
   logic [31:0] cap_bc;
   logic [7:0]  cap_data;

   always #5 clk = ~clk;

   mcu_spi_slave dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sck         (sck),
      .mosi        (mosi),
      .ssel_n      (ssel_n),
      .miso        (miso),
      .miso_oe     (miso_oe),
      .input_data  (input_data),
      .cmd_ready   (cmd_ready),
      .param_ready (param_ready),
      .cmd_data    (cmd_data),
      .param_data  (param_data),
      .byte_cnt    (byte_cnt),
      .bit_cnt     (bit_cnt)
   );

   always @(negedge clk) begin
      if (cmd_ready)   cmd_cnt++;
      if (param_ready) param_cnt++;
      if ((cmd_ready || param_ready) && strobe_prev) wide_cnt++;
      strobe_prev = cmd_ready || param_ready;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One mode-0 bit: MOSI set up in the low phase, MISO sampled at the rise.
   // On the last bit of a byte, the strobe is captured and the decoder's
   // response byte is driven as soon as the strobe is seen.
   task automatic spi_bit(input logic b, input logic last, input logic [7:0] resp,
                          output logic m);
      mosi = b;
      wait_clk(4);
      sck = 1'b1;
      m   = miso;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (last && cap_kind == 0 && (cmd_ready || param_ready)) begin
            cap_kind   = cmd_ready ? 1 : 2;
            cap_bc     = byte_cnt;
            cap_data   = cmd_ready ? cmd_data : param_data;
            input_data = resp;
         end
      end
      sck = 1'b0;
      wait_clk(4);
   endtask

   task automatic spi_byte(input logic [7:0] b, input logic [7:0] resp, output logic [7:0] m);
      logic mb;
      cap_kind = 0;
      cap_bc   = '0;
      cap_data = '0;
      for (int i = 7; i >= 0; i--) begin
         spi_bit(b[i], (i == 0), resp, mb);
         m[i] = mb;
      end
   endtask

   typedef struct {
      bit         start;     // open a frame before this byte
      bit         stop;      // close the frame after this byte
      logic [7:0] mosi_b;
      logic [7:0] resp;      // response driven on this byte's strobe
      int         exp_kind;
      int         exp_bc;
      logic [7:0] exp_data;
      logic [7:0] exp_miso;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic [7:0] got;
      logic       mb;
      logic [7:0] part;
      logic [7:0] hold_cmd, hold_param;
      int         c0, p0;

      vecs[0] = '{1'b1, 1'b0, 8'hF0, 8'hA5, 1, 1, 8'hF0, 8'h3C};
      vecs[1] = '{1'b0, 1'b1, 8'h00, 8'h66, 2, 2, 8'h00, 8'hA5};
      vecs[2] = '{1'b1, 1'b0, 8'h10, 8'h5A, 1, 1, 8'h10, 8'h66};
      vecs[3] = '{1'b0, 1'b0, 8'h11, 8'hC3, 2, 2, 8'h11, 8'h5A};
      vecs[4] = '{1'b0, 1'b0, 8'h22, 8'h81, 2, 3, 8'h22, 8'hC3};
      vecs[5] = '{1'b0, 1'b1, 8'h33, 8'h00, 2, 4, 8'h33, 8'h81};

      rst_n      = 1'b0;
      sck        = 1'b0;
      mosi       = 1'b0;
      ssel_n     = 1'b1;
      input_data = 8'h3C;
      hold_cmd   = 8'h00;
      hold_param = 8'h00;

      wait_clk(3);
      check("reset_outputs",
            {miso, miso_oe, cmd_ready, param_ready, cmd_data, param_data, bit_cnt}, '0);
      check("reset_byte_cnt", byte_cnt, '0);
      rst_n = 1'b1;
      wait_clk(4);

      // Table-driven frames
      for (int i = 0; i < 6; i++) begin
         if (vecs[i].start) begin
            ssel_n = 1'b0;
            wait_clk(8);
            check($sformatf("v%0d_miso_oe_on", i), miso_oe, 1'b1);
         end
         spi_byte(vecs[i].mosi_b, vecs[i].resp, got);
         check($sformatf("v%0d_strobe_kind", i), cap_kind, vecs[i].exp_kind);
         check($sformatf("v%0d_byte_cnt_at_strobe", i), cap_bc, vecs[i].exp_bc);
         check($sformatf("v%0d_data", i), cap_data, vecs[i].exp_data);
         check($sformatf("v%0d_miso_byte", i), got, vecs[i].exp_miso);
         check($sformatf("v%0d_byte_cnt_held", i), byte_cnt, vecs[i].exp_bc);
         if (vecs[i].exp_kind == 1) hold_cmd = vecs[i].exp_data;
         else                       hold_param = vecs[i].exp_data;
         if (vecs[i].stop) begin
            ssel_n = 1'b1;
            wait_clk(8);
            check($sformatf("v%0d_end_counters", i), {byte_cnt, bit_cnt}, '0);
            check($sformatf("v%0d_end_miso", i), {miso_oe, miso}, 2'b00);
            check($sformatf("v%0d_end_data_kept", i), {cmd_data, param_data},
                  {hold_cmd, hold_param});
         end
      end

      // Partial second byte discarded on deselect
      ssel_n = 1'b0;
      wait_clk(8);
      spi_byte(8'hD2, 8'h00, got);
      check("partial_cmd_kind", cap_kind, 1);
      check("partial_cmd_data", cap_data, 8'hD2);
      p0   = param_cnt;
      part = 8'hB7;
      for (int i = 7; i > 2; i--) spi_bit(part[i], 1'b0, 8'h00, mb);
      check("partial_bit_cnt", bit_cnt, 3'd5);
      ssel_n = 1'b1;
      wait_clk(8);
      check("partial_no_param_strobe", param_cnt - p0, 0);
      check("partial_counters_clear", {byte_cnt, bit_cnt}, '0);
      check("partial_cmd_kept", cmd_data, 8'hD2);
      ssel_n = 1'b0;
      wait_clk(8);
      spi_byte(8'h77, 8'h00, got);
      check("after_partial_kind", cap_kind, 1);
      check("after_partial_bc", cap_bc, 1);
      check("after_partial_data", cap_data, 8'h77);

      // Reset asserted mid-byte, away from any clock edge
      part = 8'hE0;
      for (int i = 7; i > 4; i--) spi_bit(part[i], 1'b0, 8'h00, mb);
      check("pre_reset_bit_cnt", bit_cnt, 3'd3);
      check("pre_reset_oe", miso_oe, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_outputs",
            {miso, miso_oe, cmd_ready, param_ready, cmd_data, param_data, bit_cnt}, '0);
      check("async_reset_byte_cnt", byte_cnt, '0);
      ssel_n = 1'b1;
      mosi   = 1'b0;
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(4);
      ssel_n = 1'b0;
      wait_clk(8);
      spi_byte(8'h5E, 8'h00, got);
      check("post_reset_kind", cap_kind, 1);
      check("post_reset_bc", cap_bc, 1);
      check("post_reset_data", cap_data, 8'h5E);

      // Two-cycle SSEL high glitch between bytes of an open frame
      ssel_n = 1'b1;
      wait_clk(2);
      ssel_n = 1'b0;
      wait_clk(8);
      spi_byte(8'h42, 8'h00, got);
`ifdef MCU_SPI_SSEL_FILTER_EN
      check("glitch_kind", cap_kind, 2);
      check("glitch_bc", cap_bc, 2);
`else
      check("glitch_kind", cap_kind, 1);
      check("glitch_bc", cap_bc, 1);
`endif
      check("glitch_data", cap_data, 8'h42);
      ssel_n = 1'b1;
      wait_clk(8);

      // SCK activity while deselected is ignored
      c0 = cmd_cnt;
      p0 = param_cnt;
      for (int i = 0; i < 16; i++) begin
         mosi = 1'($urandom_range(0, 1));
         sck  = ~sck;
         wait_clk(4);
      end
      wait_clk(4);
      check("idle_sck_no_strobes", (cmd_cnt - c0) + (param_cnt - p0), 0);
      check("idle_sck_counters", {byte_cnt, bit_cnt}, '0);
      check("idle_sck_miso", {miso_oe, miso}, 2'b00);

      check("strobe_width_one_clk", wide_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
